signal_debouncer: RTL
=====================

Name: signal_debouncer

Overview:
- Conditions a raw, asynchronous, bouncy one-bit input (button, switch, external strap) into a clean level.
- Synchronises the input into the clock domain, then only accepts a level change once it has held for a programmable number of consecutive cycles.
- Output feeds directly into the pulse-family edge detectors (rising/falling/any), which then produce exactly one pulse per real transition.

Parameters:
STABLE_CYCLES  16  consecutive sampled cycles a new level must hold before acceptance; legal range ≥1
SYNC_STAGES    2   synchroniser flip-flops in front of the filter; 0 = input already synchronous, bypass
RESET_VALUE    0   value of synchroniser flops and debounced output during/after reset

Ports:
clock      input   1  clock
reset      input   1  synchronous reset, active-high
signal     input   1  raw input, may be asynchronous and bouncing
debounced  output  1  filtered, glitch-free level
bouncing   output  1  high while a candidate level change is being qualified

Behaviour:
- Reset:
  - The one clock and the synchronous active-high reset are fixed. Reset is sampled on the rising clock edge only.
  - While reset is high at an edge: all synchroniser flops and debounced take RESET_VALUE; counter = 0; state = STABLE; bouncing = 0.
- Synchroniser:
  - SYNC_STAGES-deep flop chain on signal.
  - Sampled value s = last stage, or signal itself when SYNC_STAGES = 0.
- State machine:
  - States: STABLE, CHANGING.
  - Counter width: $clog2(STABLE_CYCLES+1).
- Update at each rising clock edge, when not in reset:
  - s == debounced: counter <= 0, state <= STABLE. This rejects a glitch and cancels any pending change.
  - s != debounced and counter+1 == STABLE_CYCLES: debounced <= s, counter <= 0, state <= STABLE.
  - s != debounced otherwise: counter <= counter+1, state <= CHANGING.
- bouncing = (state == CHANGING). Registered output, no combinational path from signal.
- Latency:
  - A clean step on signal set before edge E1 appears on debounced after edge E(SYNC_STAGES+STABLE_CYCLES).
  - STABLE_CYCLES = 1 with SYNC_STAGES = 0 gives a plain one-cycle register.
- Glitch rejection: any excursion of s lasting fewer than STABLE_CYCLES consecutive sampled cycles never changes debounced.
- A continuously alternating input never changes debounced.
- Counter never exceeds STABLE_CYCLES-1; no wrap-around is possible.
- Reset mid-qualification discards the pending change. After reset, qualification restarts from zero against RESET_VALUE.
- Input held at ≠ RESET_VALUE through reset: accepted after the full latency once reset deasserts.
- No X propagation: all state is reset.

Test Plan (bench parameters STABLE_CYCLES=4, SYNC_STAGES=2, RESET_VALUE=0; stimulus applied on negedge, checks on posedge):
1. Reset: hold reset 2 cycles with signal=1 → debounced=0 and bouncing=0 during reset. After release, debounced=1 at the 6th edge.
2. Clean rise: signal 0→1 before E1 → bouncing=1 after E3, E4 and E5; debounced=1 and bouncing=0 after E6. Clean fall is symmetric back to 0.
3. Glitch: signal=1 for exactly 3 cycles then 0 → bouncing pulses for 3 cycles; debounced stays 0 throughout. Repeat with 4 cycles → debounced=1 after E6.
4. Bounce train: toggle signal every cycle for 20 cycles, then hold 1 → debounced stays 0 during the toggling. debounced=1 exactly 6 edges after the final 0→1.
5. Reset mid-operation: assert reset when counter=2 during a rise (signal still 1) → counter cleared, debounced=0. After release, debounced=1 only after a further 6 edges.
6. Random: 1000 cycles of random signal with random run lengths 1–8 → debounced and bouncing match a cycle-accurate reference model every edge; the downstream rising_edge_detector pulses once per accepted 0→1.

Source files
------------

// File: rtl/signal_debouncer.sv
// Synchronises a raw one-bit input and accepts a new level only after it has held for STABLE_CYCLES sampled cycles.
// Latency: SYNC_STAGES + STABLE_CYCLES edges for a clean step; no backpressure, level in / level out.
module signal_debouncer #(
    parameter int unsigned STABLE_CYCLES = 16,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter bit          RESET_VALUE   = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic signal,
    output logic debounced,
    output logic bouncing
);

    localparam int unsigned     CW   = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0]   LAST = CW'(STABLE_CYCLES - 1);

    typedef enum logic {
        STABLE   = 1'b0,
        CHANGING = 1'b1
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] count, count_nxt;
    logic          level, level_nxt;
    logic          sampled;

    generate
        if (SYNC_STAGES == 0) begin : g_bypass
            assign sampled = signal;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync;

            always_ff @(posedge clock) begin
                if (reset) begin
                    sync <= {SYNC_STAGES{RESET_VALUE}};
                end else begin
                    sync[0] <= signal;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        sync[i] <= sync[i-1];
                    end
                end
            end

            assign sampled = sync[SYNC_STAGES-1];
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= STABLE;
            count <= '0;
            level <= RESET_VALUE;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            level <= level_nxt;
        end
    end

    // Any sample matching the current level cancels a pending change outright.
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        level_nxt = level;
        if (sampled == level) begin
            state_nxt = STABLE;
            count_nxt = '0;
        end else if (count == LAST) begin
            state_nxt = STABLE;
            count_nxt = '0;
            level_nxt = sampled;
        end else begin
            state_nxt = CHANGING;
            count_nxt = count + CW'(1);
        end
    end

    always_comb begin
        debounced = level;
        bouncing  = (state == CHANGING);
    end

endmodule
